// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN = 1'b0,
    MD  = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // The younger producer (EX) holds the newest value, so it wins over MEM.
  function automatic logic [1:0] fwd_code(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       fwd_code = FWD_EX;
    else if (mem_hit) fwd_code = FWD_MEM;
    else              fwd_code = FWD_RF;
  endfunction

endpackage

// File: rtl/raw_cmp.sv
// Per-operand dependency comparator: checks one ID source register against
// the EX and MEM destinations. $0 never creates a dependency.
module raw_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] r,
  input  logic       uses,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  output logic       ex_hit,
  output logic       mem_hit,
  output logic       load_hit
);

  logic live;

  assign live     = uses && (r != REG_ZERO);
  assign ex_hit   = live && ex_regwrite  && (ex_rd  == r);
  assign mem_hit  = live && mem_regwrite && (mem_rd == r);
  assign load_hit = live && ex_memread   && (ex_rd  == r);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use / RAW stalls,
// taken-branch flushes, multi-cycle mult/div occupancy, data-memory freeze
// and a saturating stall-cycle counter.
// Optional feature macro: PIPE_FWD_EN (operand forwarding; only load-use stalls).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_md_start,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             ex_branch_taken,
  input  logic             mem_wait,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  // MD_LAT >= 2, so MD_LAT-1 always fits in $clog2(MD_LAT) bits.
  localparam int MD_W = $clog2(MD_LAT);

  state_t          state, state_nxt;
  logic [MD_W-1:0] md_cnt, md_cnt_nxt;

  // Index 0 = rs (operand A), index 1 = rt (operand B).
  logic [1:0][4:0] src;
  logic [1:0]      use_src;
  logic [1:0]      ex_hit, mem_hit, load_hit;
  logic            hazard;

  assign src     = {id_rt, id_rs};
  assign use_src = {id_uses_rt, id_uses_rs};

  for (genvar i = 0; i < 2; i++) begin : g_cmp
    raw_cmp u_cmp (
      .r            (src[i]),
      .uses         (use_src[i]),
      .ex_rd        (ex_rd),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .ex_hit       (ex_hit[i]),
      .mem_hit      (mem_hit[i]),
      .load_hit     (load_hit[i])
    );
  end

`ifdef PIPE_FWD_EN
  // With forwarding only a load in EX cannot be bypassed in time.
  assign hazard = |load_hit;
`else
  // Without forwarding any pending writer in EX or MEM must drain first.
  assign hazard = |{ex_hit, mem_hit, load_hit};
`endif

  assign md_busy = (state == MD);

  // FSM state and mult/div countdown register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Pipeline controls and next state; memory wait dominates everything.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    if (mem_wait) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end else if (state == RUN && ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state == MD) begin
      // EX only holds bubbles here, so a branch cannot be resolving.
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
      if (md_cnt == '0) state_nxt  = RUN;
      else              md_cnt_nxt = md_cnt - 1'b1;
    end else if (hazard) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end else if (id_md_start) begin
      state_nxt  = MD;
      md_cnt_nxt = MD_W'(MD_LAT - 1);
    end
  end

  // Count every cycle the PC is held, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            stall_cnt <= '0;
    else if (!pc_we && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

`ifdef PIPE_FWD_EN
  // Forward selects travel with the instruction into ID/EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else if (!mem_wait) begin
      if (idex_flush) begin
        fwd_a <= FWD_RF;
        fwd_b <= FWD_RF;
      end else begin
        fwd_a <= fwd_code(ex_hit[0], mem_hit[0]);
        fwd_b <= fwd_code(ex_hit[1], mem_hit[1]);
      end
    end
  end
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

endmodule
